// File: rtl/slc3_io_pkg.sv
// slc3_io_pkg: shared channel state encoding and button index names for the SLC-3 input front-end
package slc3_io_pkg;
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} btn_state_t;
  localparam int BTN_RUN      = 0;
  localparam int BTN_CONTINUE = 1;
endpackage

// File: rtl/slc3_input_conditioner_channel.sv
// debounce_channel: 2-FF synchroniser, debounce FSM with stability counter, registered level and edge pulses
module debounce_channel
  import slc3_io_pkg::*;
#(
  parameter int D = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic fall
);
  localparam int CW = $clog2(D);
  localparam logic [CW-1:0] CMAX = CW'(D - 1);
  logic meta_q, s_q;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, fall_q, fall_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        state_d = s_q ? WAIT_HIGH : IDLE_LOW;
        cnt_d   = CW'(s_q);
      end
      WAIT_HIGH: begin
        if (!s_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CMAX) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      IDLE_HIGH: begin
        state_d = s_q ? IDLE_HIGH : WAIT_LOW;
        cnt_d   = CW'(!s_q);
      end
      WAIT_LOW: begin
        if (s_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CMAX) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE_LOW;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= raw;
      s_q     <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      fall_q  <= fall_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
  assign fall  = fall_q;
endmodule

// File: rtl/slc3_input_conditioner.sv
// slc3_input_conditioner: debounces board buttons into one-shot Run/Continue events and synchronises switches
module slc3_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_press,
  output logic [NUM_BTN-1:0]  btn_release,
  output logic [SW_WIDTH-1:0] sw_sync
);
  logic [SW_WIDTH-1:0] sw_meta_q, sw_sync_q;
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(.D(DEBOUNCE_CYCLES)) u_ch (
      .clk  (Clk),
      .rst_n(Reset_n),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .fall (btn_release[i])
    );
  end
  // switches are levels the processor samples at will, so synchronise only
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_raw;
      sw_sync_q <= sw_meta_q;
    end
  end
  assign sw_sync = sw_sync_q;
endmodule

// File: tb/tb_slc3_input_conditioner.sv
// tb_slc3_input_conditioner: table-driven vectors plus hand sequences for glitch and reset corners, D=4
module tb_slc3_input_conditioner;
  import slc3_io_pkg::*;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [1:0]  btn_raw = '0;
  logic [15:0] sw_raw = '0;
  logic [1:0]  btn_level, btn_press, btn_release;
  logic [15:0] sw_sync;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [1:0]  btn;
    logic [15:0] sw;
    logic [1:0]  lvl, prs, rel;
    logic [15:0] swx;
  } vec_t;
  vec_t tbl[28];
  slc3_input_conditioner #(.NUM_BTN(2), .SW_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .sw_sync(sw_sync)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " level"}, 32'(btn_level), 0);
    chk({nm, " press"}, 32'(btn_press), 0);
    chk({nm, " release"}, 32'(btn_release), 0);
    chk({nm, " sw"}, 32'(sw_sync), 0);
  endtask
  initial begin
    int np, nr, tp, tr;
    tbl[0]  = '{2'b01, 16'h000B, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[1]  = '{2'b01, 16'h000B, 2'b00, 2'b00, 2'b00, 16'h000B};
    tbl[2]  = '{2'b01, 16'h0001, 2'b00, 2'b00, 2'b00, 16'h000B};
    tbl[3]  = '{2'b01, 16'h000B, 2'b00, 2'b00, 2'b00, 16'h0001};
    tbl[4]  = '{2'b01, 16'hFFFF, 2'b00, 2'b00, 2'b00, 16'h000B};
    tbl[5]  = '{2'b01, 16'h0000, 2'b01, 2'b01, 2'b00, 16'hFFFF};
    tbl[6]  = '{2'b01, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000};
    tbl[7]  = '{2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000};
    tbl[8]  = '{2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000};
    tbl[9]  = '{2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000};
    tbl[10] = '{2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000};
    tbl[11] = '{2'b00, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000};
    tbl[12] = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h0000};
    tbl[13] = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[14] = '{2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[15] = '{2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[16] = '{2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[17] = '{2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[18] = '{2'b11, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[19] = '{2'b11, 16'h0000, 2'b11, 2'b11, 2'b00, 16'h0000};
    tbl[20] = '{2'b11, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0000};
    tbl[21] = '{2'b00, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0000};
    tbl[22] = '{2'b00, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0000};
    tbl[23] = '{2'b00, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0000};
    tbl[24] = '{2'b00, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0000};
    tbl[25] = '{2'b00, 16'h0000, 2'b11, 2'b00, 2'b00, 16'h0000};
    tbl[26] = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b11, 16'h0000};
    tbl[27] = '{2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000};
    #2;
    Reset_n = 1'b0;
    btn_raw = 2'($urandom);
    sw_raw  = 16'($urandom);
    #1;
    chk_zero("async reset");
    for (int i = 0; i < 2; i++) begin
      tick();
      btn_raw = 2'($urandom);
      sw_raw  = 16'($urandom);
      chk_zero("held reset");
    end
    btn_raw = '0;
    sw_raw  = '0;
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("post reset idle");
    end
    // single press, switch pass-through, dual press/release
    for (int i = 0; i < 28; i++) begin
      btn_raw = tbl[i].btn;
      sw_raw  = tbl[i].sw;
      tick();
      chk($sformatf("vec%0d level", i), 32'(btn_level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d press", i), 32'(btn_press), 32'(tbl[i].prs));
      chk($sformatf("vec%0d release", i), 32'(btn_release), 32'(tbl[i].rel));
      chk($sformatf("vec%0d sw", i), 32'(sw_sync), 32'(tbl[i].swx));
    end
    // 3-cycle glitch on Continue is rejected
    btn_raw[BTN_CONTINUE] = 1'b1;
    repeat (3) tick();
    btn_raw[BTN_CONTINUE] = 1'b0;
    np = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      np += int'(btn_press[BTN_CONTINUE]);
      chk("glitch3 level", 32'(btn_level[BTN_CONTINUE]), 0);
    end
    chk("glitch3 presses", np, 0);
    // 4 raw cycles high reaches D stable synced cycles: one press, then one release
    btn_raw[BTN_CONTINUE] = 1'b1;
    np = 0; nr = 0; tp = 0; tr = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (t == 4) btn_raw[BTN_CONTINUE] = 1'b0;
      if (btn_press[BTN_CONTINUE]) begin np++; tp = t; end
      if (btn_release[BTN_CONTINUE]) begin nr++; tr = t; end
    end
    chk("pulse4 presses", np, 1);
    chk("pulse4 press tick", tp, 6);
    chk("pulse4 releases", nr, 1);
    chk("pulse4 release tick", tr, 10);
    chk("pulse4 final level", 32'(btn_level), 0);
    // reset during WAIT_HIGH with Run held
    btn_raw[BTN_RUN] = 1'b1;
    repeat (4) tick();
    Reset_n = 1'b0;
    #1;
    chk("midwait reset level", 32'(btn_level), 0);
    chk("midwait reset press", 32'(btn_press), 0);
    tick();
    Reset_n = 1'b1;
    np = 0; tp = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (btn_press[BTN_RUN]) begin np++; tp = t; end
    end
    chk("rerun presses", np, 1);
    chk("rerun press tick", tp, 6);
    chk("rerun level", 32'(btn_level), 32'h1);
    // reset while a press pulse is high
    btn_raw = '0;
    repeat (10) tick();
    chk("idle before inflight", 32'(btn_level), 0);
    btn_raw[BTN_RUN] = 1'b1;
    repeat (6) tick();
    chk("inflight press high", 32'(btn_press), 32'h1);
    Reset_n = 1'b0;
    #1;
    chk("inflight press cleared", 32'(btn_press), 0);
    chk("inflight level cleared", 32'(btn_level), 0);
    tick();
    btn_raw = '0;
    Reset_n = 1'b1;
    np = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      np += int'(btn_press[BTN_RUN]);
    end
    chk("after inflight presses", np, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
